inter_to_wb: RTL

INTER_TO_WB -- requirements
Module: inter_to_wb

---
 rtl/inter_to_wb_pkg.sv | 12 +
 rtl/inter_to_wb.sv | 120 ++++++++++++
 2 files changed

// File: rtl/inter_to_wb_pkg.sv
// rtl/inter_to_wb_pkg.sv - soric interconnect shared types: bridge FSM encoding and error data word
package inter_to_wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] ERR_DATA = 32'hBADC_0DE5;

endpackage

// File: rtl/inter_to_wb.sv
// rtl/inter_to_wb.sv - interconnect slave to Wishbone master bridge, one transfer at a time
// Optional Wishbone wait limit enabled by defining INTER_TO_WB_TIMEOUT_EN.
module inter_to_wb
  import inter_to_wb_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 11,
  parameter logic [31:0] WB_BASE    = 32'h3000_0000,
  parameter int          TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  slave_data_req_i,
  input  logic [ADDR_WIDTH-1:0] slave_data_addr_i,
  input  logic                  slave_data_we_i,
  input  logic [3:0]            slave_data_be_i,
  input  logic [DATA_WIDTH-1:0] slave_data_wdata_i,
  output logic [DATA_WIDTH-1:0] slave_data_rdata_o,
  output logic                  slave_data_rvalid_o,
  output logic                  slave_data_gnt_o,
  output logic                  wbm_cyc_o,
  output logic                  wbm_stb_o,
  output logic                  wbm_we_o,
  output logic [3:0]            wbm_sel_o,
  output logic [31:0]           wbm_adr_o,
  output logic [DATA_WIDTH-1:0] wbm_dat_o,
  input  logic [DATA_WIDTH-1:0] wbm_dat_i,
  input  logic                  wbm_ack_i,
  input  logic                  wbm_err_i,
  output logic                  error_o
);

  state_t      state;
  logic [31:0] adr_off;

  // Wishbone side is word addressed: byte offset bits are forced to zero.
  assign adr_off = 32'({slave_data_addr_i[ADDR_WIDTH-1:2], 2'b00});

  assign slave_data_gnt_o = (state == IDLE) && slave_data_req_i;

  logic unused_ok;
  assign unused_ok = &{1'b0, slave_data_addr_i[1:0], (TIMEOUT == 0)};

`ifdef INTER_TO_WB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] tmo_cnt;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= IDLE;
      wbm_cyc_o           <= 1'b0;
      wbm_stb_o           <= 1'b0;
      wbm_we_o            <= 1'b0;
      wbm_sel_o           <= 4'b0;
      wbm_adr_o           <= 32'b0;
      wbm_dat_o           <= '0;
      slave_data_rdata_o  <= '0;
      slave_data_rvalid_o <= 1'b0;
      error_o             <= 1'b0;
`ifdef INTER_TO_WB_TIMEOUT_EN
      tmo_cnt             <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          slave_data_rvalid_o <= 1'b0;
          error_o             <= 1'b0;
          if (slave_data_req_i) begin
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= slave_data_we_i;
            wbm_sel_o <= slave_data_be_i;
            wbm_adr_o <= WB_BASE + adr_off;
            wbm_dat_o <= slave_data_wdata_i;
            state     <= BUS;
`ifdef INTER_TO_WB_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
          end
        end
        BUS: begin
          // err wins over a simultaneous ack
          if (wbm_err_i || wbm_ack_i) begin
            wbm_cyc_o           <= 1'b0;
            wbm_stb_o           <= 1'b0;
            slave_data_rvalid_o <= 1'b1;
            state               <= RESP;
            if (wbm_err_i) begin
              slave_data_rdata_o <= ERR_DATA;
              error_o            <= 1'b1;
            end else if (!wbm_we_o) begin
              slave_data_rdata_o <= wbm_dat_i;
            end
          end
`ifdef INTER_TO_WB_TIMEOUT_EN
          else if (tmo_cnt == CNT_LAST) begin
            wbm_cyc_o           <= 1'b0;
            wbm_stb_o           <= 1'b0;
            slave_data_rvalid_o <= 1'b1;
            slave_data_rdata_o  <= ERR_DATA;
            error_o             <= 1'b1;
            state               <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          slave_data_rvalid_o <= 1'b0;
          error_o             <= 1'b0;
          state               <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
